// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD sequencer and its SPI write serializer.
package lcd_pkg;

    localparam int LCD_WORD_W = 9;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } lcd_state_e;

endpackage

// File: rtl/lcd_spi_clk_div.sv
// Half-period tick generator for the LCD SPI clock; holds at zero while disabled.
module lcd_spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == CNT_LAST);
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_spi_write.sv
// Serializes one 9-bit {dc, byte} word onto a 4-wire mode-0 SPI bus, MSB first.
// Define LCD_SPI_CS_BURST_EN to keep CS low across back-to-back words.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic                  sys_clk_50MHz,
    input  logic                  sys_rst_n,
    input  logic                  en_write,
    input  logic [LCD_WORD_W-1:0] data_in,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  lcd_cs,
    output logic                  lcd_dc,
    output logic                  lcd_sck,
    output logic                  lcd_mosi
);

    localparam int               GAP_W    = $clog2(CS_GAP) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    lcd_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             cs_q, cs_d;
    logic             dc_q, dc_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             div_en;
    logic             div_tick;

    assign div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

    lcd_spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (sys_clk_50MHz),
        .rst_n (sys_rst_n),
        .en    (div_en),
        .tick  (div_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        cs_d      = cs_q;
        dc_d      = dc_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (en_write) begin
                    state_d   = ST_SETUP;
                    shift_d   = data_in[7:0];
                    bit_cnt_d = 3'd0;
                    cs_d      = 1'b0;
                    dc_d      = data_in[8];
                    mosi_d    = data_in[7];
                    busy_d    = 1'b1;
                end else begin
                    cs_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (div_tick) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_tick) begin
                    if (sck_q) begin
                        // Falling edge: advance MOSI, but hold it after the last bit.
                        sck_d = 1'b0;
                        if (bit_cnt_q != 3'd7) begin
                            mosi_d  = shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end else if (bit_cnt_q == 3'd7) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`ifdef LCD_SPI_CS_BURST_EN
                        cs_d    = ~en_write;
`else
                        cs_d    = 1'b1;
`endif
                    end else begin
                        sck_d     = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            cs_q      <= 1'b1;
            dc_q      <= LCD_CMD;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            cs_q      <= cs_d;
            dc_q      <= dc_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_done  = done_q;
    assign busy     = busy_q;
    assign lcd_cs   = cs_q;
    assign lcd_dc   = dc_q;
    assign lcd_sck  = sck_q;
    assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_lcd_spi_write.sv
// Scoreboard bench: dut A (CLK_DIV=2) for single-word cases, dut B (CLK_DIV=1) for a 14-word stream.
module tb_lcd_spi_write;

`ifdef LCD_SPI_CS_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        logic       dc;
        logic [7:0] bits;
        int         cs_low;
        int         period;
        int         gap;
        logic       cs_done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [8:0] data_a, data_b;
    logic       done_a, busy_a, cs_a, dc_a, sck_a, mosi_a;
    logic       done_b, busy_b, cs_b, dc_b, sck_b, mosi_b;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [8:0] words_b [14] = '{9'h12c, 9'h1ff, 9'h100, 9'h0a5, 9'h15a, 9'h1c3, 9'h03c,
                                 9'h181, 9'h17e, 9'h0f0, 9'h10f, 9'h1aa, 9'h055, 9'h1e7};

    always #5 clk = ~clk;

    lcd_spi_write #(.CLK_DIV(2), .CS_GAP(2)) u_dut_a (
        .sys_clk_50MHz (clk),    .sys_rst_n (rst_n),
        .en_write      (en_a),   .data_in   (data_a),
        .wr_done       (done_a), .busy      (busy_a),
        .lcd_cs        (cs_a),   .lcd_dc    (dc_a),
        .lcd_sck       (sck_a),  .lcd_mosi  (mosi_a)
    );

    lcd_spi_write #(.CLK_DIV(1), .CS_GAP(2)) u_dut_b (
        .sys_clk_50MHz (clk),    .sys_rst_n (rst_n),
        .en_write      (en_b),   .data_in   (data_b),
        .wr_done       (done_b), .busy      (busy_b),
        .lcd_cs        (cs_b),   .lcd_dc    (dc_b),
        .lcd_sck       (sck_b),  .lcd_mosi  (mosi_b)
    );

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic dc, input logic [7:0] bits, input int cs_low,
                                input int period, input int gap, input logic cs_done);
        exp_t e;
        e.dc = dc; e.bits = bits; e.cs_low = cs_low;
        e.period = period; e.gap = gap; e.cs_done = cs_done;
        return e;
    endfunction

    // Monitor: capture MOSI at each SCK rise, compare against the queue on every wr_done.
    logic [7:0] m_bits [2];
    int         m_nb [2], m_cslow [2], m_gap [2], m_last [2];
    logic       m_psck [2], m_pdone [2], m_dc [2];

    always @(negedge clk) begin
        logic v_cs, v_sck, v_mosi, v_dc, v_done;
        exp_t e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            v_cs   = (d == 0) ? cs_a   : cs_b;
            v_sck  = (d == 0) ? sck_a  : sck_b;
            v_mosi = (d == 0) ? mosi_a : mosi_b;
            v_dc   = (d == 0) ? dc_a   : dc_b;
            v_done = (d == 0) ? done_a : done_b;
            if (!rst_n) begin
                m_bits[d] = '0; m_nb[d] = 0; m_cslow[d] = 0; m_gap[d] = 0;
                m_psck[d] = 1'b0; m_pdone[d] = 1'b0; m_dc[d] = 1'b0;
            end else begin
                if (m_pdone[d]) chk($sformatf("dut%0d wr_done width", d), v_done, 0);
                if (v_sck && !m_psck[d]) begin
                    chk($sformatf("dut%0d cs at sck rise", d), v_cs, 0);
                    m_bits[d] = {m_bits[d][6:0], v_mosi};
                    m_nb[d]++;
                    m_dc[d] = v_dc;
                end
                if (v_done) begin
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected wr_done at cycle %0d, expected none", d, cyc);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        $display("dut%0d word done: dc=%0d bits=%02h cs_low=%0d gap=%0d period=%0d",
                                 d, m_dc[d], m_bits[d], m_cslow[d], m_gap[d], cyc - m_last[d]);
                        chk($sformatf("dut%0d bits", d), m_bits[d], e.bits);
                        chk($sformatf("dut%0d bit count", d), m_nb[d], 8);
                        chk($sformatf("dut%0d dc", d), m_dc[d], e.dc);
                        chk($sformatf("dut%0d cs at done", d), v_cs, e.cs_done);
                        if (e.cs_low >= 0) chk($sformatf("dut%0d cs low cycles", d), m_cslow[d], e.cs_low);
                        if (e.period >= 0) chk($sformatf("dut%0d done period", d), cyc - m_last[d], e.period);
                        if (e.gap >= 0)    chk($sformatf("dut%0d cs high gap", d), m_gap[d], e.gap);
                    end
                    m_last[d] = cyc; m_nb[d] = 0; m_cslow[d] = 0; m_gap[d] = 0;
                end else if (!v_cs) begin
                    m_cslow[d]++;
                end else begin
                    m_gap[d]++;
                end
                m_psck[d]  = v_sck;
                m_pdone[d] = v_done;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int which, input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (((which == 0) ? busy_a : busy_b) == 1'b0) break;
            step(1);
        end
        chk({name, " idle timeout"}, (i < 400) ? 1 : 0, 1);
    endtask

    task automatic wait_done(input int which, input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            if (((which == 0) ? done_a : done_b) == 1'b1) break;
            step(1);
        end
        chk({name, " wr_done timeout"}, (i < 400) ? 1 : 0, 1);
    endtask

    initial begin
        int   nr, bad;
        logic prev;
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; data_a = '0; data_b = '0;
        step(3);
        chk("A rst cs", cs_a, 1);    chk("A rst sck", sck_a, 0);   chk("A rst mosi", mosi_a, 0);
        chk("A rst dc", dc_a, 0);    chk("A rst done", done_a, 0); chk("A rst busy", busy_a, 0);
        chk("B rst cs", cs_b, 1);    chk("B rst busy", busy_b, 0);
        rst_n = 1'b1;
        step(2);

        // Abort 9'h036 at the fifth SCK rising edge.
        data_a = 9'h036; en_a = 1'b1;
        step(1);
        en_a = 1'b0;
        nr = 0;
        for (int i = 0; i < 200 && nr < 5; i++) begin
            prev = sck_a;
            step(1);
            if (sck_a && !prev) nr++;
        end
        chk("abort reached sck edge 5", nr, 5);
        rst_n = 1'b0;
        #1;
        $display("abort: cs=%0d sck=%0d mosi=%0d dc=%0d busy=%0d", cs_a, sck_a, mosi_a, dc_a, busy_a);
        chk("abort cs", cs_a, 1);   chk("abort sck", sck_a, 0); chk("abort mosi", mosi_a, 0);
        chk("abort dc", dc_a, 0);   chk("abort done", done_a, 0); chk("abort busy", busy_a, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // Single command word; a data_in change after the latch must be ignored.
        exp_q0.push_back(mk(1'b0, 8'b0011_0110, 34, -1, -1, 1'b1));
        data_a = 9'h036; en_a = 1'b1;
        step(1);
        en_a = 1'b0; data_a = 9'h1ff;
        wait_idle(0, "cmd 036");
        step(3);

        exp_q0.push_back(mk(1'b1, 8'b1110_1111, 34, -1, -1, 1'b1));
        data_a = 9'h1ef; en_a = 1'b1;
        step(1);
        en_a = 1'b0; data_a = 9'h000;
        wait_idle(0, "data 1ef");
        step(3);

        // Back-to-back with en_write held high.
        exp_q0.push_back(mk(1'b0, 8'b0010_1010, 34, -1, -1, BURST ? 1'b0 : 1'b1));
        exp_q0.push_back(mk(1'b1, 8'b0000_0000, BURST ? 37 : 34, 38, BURST ? 0 : 3, 1'b1));
        data_a = 9'h02a; en_a = 1'b1;
        step(1);
        data_a = 9'h100;
        wait_done(0, "b2b first");
        step(5);
        en_a = 1'b0;
        wait_idle(0, "b2b second");
        step(3);

        // en_write dropped two cycles after the latch.
        exp_q0.push_back(mk(1'b1, 8'b0101_0101, 34, -1, -1, 1'b1));
        data_a = 9'h155; en_a = 1'b1;
        step(1);
        step(2);
        en_a = 1'b0; data_a = 9'h0aa;
        wait_idle(0, "drop 155");
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (busy_a || !cs_a || sck_a) bad++;
        end
        chk("A stays idle", bad, 0);
        chk("A queue drained", exp_q0.size(), 0);

        // Fourteen-word stream on the CLK_DIV=1 instance.
        for (int k = 0; k < 14; k++) begin
            exp_q1.push_back(mk(words_b[k][8], words_b[k][7:0],
                                (k == 0) ? 17 : (BURST ? 20 : 17),
                                (k == 0) ? -1 : 21,
                                (k == 0) ? -1 : (BURST ? 0 : 3),
                                BURST ? 1'b0 : 1'b1));
        end
        data_b = words_b[0]; en_b = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step(1);
            wait_done(1, $sformatf("stream word %0d", k));
            if (k < 13) data_b = words_b[k + 1];
            else        en_b = 1'b0;
        end
        step(1);
        chk("B cs during final gap", cs_b, BURST ? 0 : 1);
        wait_idle(1, "stream end");
        step(1);
        chk("B cs released in idle", cs_b, 1);
        step(3);
        chk("B busy after stream", busy_b, 0);
        chk("B queue drained", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
